// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the encoder sample controller.
package enc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARM     = 2'b01;
    localparam logic [1:0] ST_COUNT   = 2'b11;
    localparam logic [1:0] ST_CAPTURE = 2'b10;

    localparam logic [15:0] CNT_SAT_POS = 16'h7FFF;
    localparam logic [15:0] CNT_SAT_NEG = 16'h8001;

    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARM     = ST_ARM,
        COUNT   = ST_COUNT,
        CAPTURE = ST_CAPTURE
    } state_e;

endpackage

// File: rtl/encoder_sample_ctrl_if.sv
// Control/status bundle between the register layer, the 4x counter and the sample controller.
interface encoder_sample_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 24,
    parameter int POS_W = 32
);
    logic                    enable;
    logic                    single;
    logic                    start;
    logic [WIN_W-1:0]        cfg_period;
    logic                    pos_clr;
    logic signed [CNT_W-1:0] cnt_in;
    logic                    cnt_clr_n;
    logic signed [CNT_W-1:0] speed_sample;
    logic                    speed_valid;
    logic                    speed_sat;
    logic signed [POS_W-1:0] position;
    logic [15:0]             win_count;
    logic                    busy;

    modport master (
        output enable, single, start, cfg_period, pos_clr, cnt_in,
        input  cnt_clr_n, speed_sample, speed_valid, speed_sat, position, win_count, busy
    );

    modport slave (
        input  enable, single, start, cfg_period, pos_clr, cnt_in,
        output cnt_clr_n, speed_sample, speed_valid, speed_sat, position, win_count, busy
    );
endinterface

// File: rtl/enc_window_timer.sv
// Loadable down-counter that stops at zero; zero_o marks the last COUNT cycle of a window.
module enc_window_timer #(
    parameter int WIN_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [WIN_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i && (value_q != '0)) begin
            value_d = value_q - WIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign zero_o = (value_q == '0);
endmodule

// File: rtl/encoder_sample_ctrl.sv
// Splits the encoder count into back-to-back windows of P cycles, captures each window
// as a signed speed sample and integrates samples into a wrapping position accumulator.
module encoder_sample_ctrl
    import enc_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int WIN_W = 24,
    parameter int POS_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    encoder_sample_ctrl_if.slave bus
);
    state_e                  state_q, state_d;
    logic                    tmr_load, tmr_dec, tmr_zero;
    logic                    capture;
    logic                    cnt_clr_n;
    logic [WIN_W-1:0]        period_eff, tmr_load_val;
    logic signed [CNT_W-1:0] sample_q;
    logic                    sat_q, sat_d;
    logic                    valid_q;
    logic signed [POS_W-1:0] pos_q, pos_d, cnt_ext;
    logic [15:0]             win_cnt_q;

    // Timer runs P-1 COUNT cycles; the clear cycle (ARM or CAPTURE) makes up the P-th.
    assign period_eff   = (bus.cfg_period < WIN_W'(MIN_PERIOD)) ? WIN_W'(MIN_PERIOD)
                                                                 : bus.cfg_period;
    assign tmr_load_val = period_eff - WIN_W'(MIN_PERIOD);

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        capture   = 1'b0;
        cnt_clr_n = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && (!bus.single || bus.start)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                cnt_clr_n = 1'b1;
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = CAPTURE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                // The capture clear cycle doubles as the restart of the next window.
                if (bus.enable && !bus.single) begin
                    tmr_load = 1'b1;
                    state_d  = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    enc_window_timer #(
        .WIN_W (WIN_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign cnt_ext = {{(POS_W-CNT_W){bus.cnt_in[CNT_W-1]}}, bus.cnt_in};
    assign sat_d   = (bus.cnt_in == CNT_SAT_POS) || (bus.cnt_in == CNT_SAT_NEG);

    // A clear landing with a capture applies first, so the new sample survives.
    always_comb begin
        pos_d = bus.pos_clr ? '0 : pos_q;
        if (capture) begin
            pos_d = pos_d + cnt_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            pos_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= capture;
            pos_q   <= pos_d;
            if (capture) begin
                sample_q  <= bus.cnt_in;
                sat_q     <= sat_d;
                win_cnt_q <= win_cnt_q + 16'd1;
            end
        end
    end

    assign bus.cnt_clr_n    = cnt_clr_n;
    assign bus.speed_sample = sample_q;
    assign bus.speed_valid  = valid_q;
    assign bus.speed_sat    = sat_q;
    assign bus.position     = pos_q;
    assign bus.win_count    = win_cnt_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Directed bench for encoder_sample_ctrl: windowing, single-shot, saturation, abort, pos_clr, reset.
module tb_encoder_sample_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    encoder_sample_ctrl_if #(.CNT_W(16), .WIN_W(24), .POS_W(32)) bus ();

    encoder_sample_ctrl #(.CNT_W(16), .WIN_W(24), .POS_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.enable     = 1'b0;
        bus.single     = 1'b0;
        bus.start      = 1'b0;
        bus.pos_clr    = 1'b0;
        bus.cnt_in     = '0;
        bus.cfg_period = 24'd10;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.single = 1'b0; bus.start = 1'b0; bus.pos_clr = 1'b0;
        bus.cnt_in = 16'h0123; bus.cfg_period = 24'd10;
        rst = 1'b1;
        step();
        checks++; if (bus.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", bus.cnt_clr_n); end
        checks++; if (bus.speed_sample !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h want 0000", bus.speed_sample); end
        checks++; if (bus.speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.speed_valid); end
        checks++; if (bus.speed_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", bus.speed_sat); end
        checks++; if (bus.position !== 32'h0) begin errors++; $display("FAIL reset_pos: got %h want 0", bus.position); end
        checks++; if (bus.win_count !== 16'h0) begin errors++; $display("FAIL reset_win: got %h want 0", bus.win_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        logic exp_clr, exp_vld;
        do_reset();
        bus.cfg_period = 24'd10; bus.single = 1'b0; bus.enable = 1'b1;
        for (int k = 0; k < 35; k++) begin
            bus.cnt_in = 16'(k);
            exp_clr = !((k == 0) || (k == 1) || ((k >= 11) && ((k - 11) % 10 == 0)));
            exp_vld = (k >= 12) && ((k - 12) % 10 == 0);
            checks++; if (bus.cnt_clr_n !== exp_clr) begin errors++; $display("FAIL cont_clr k=%0d: got %b want %b", k, bus.cnt_clr_n, exp_clr); end
            checks++; if (bus.speed_valid !== exp_vld) begin errors++; $display("FAIL cont_valid k=%0d: got %b want %b", k, bus.speed_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (bus.speed_sample !== 16'(k - 1)) begin errors++; $display("FAIL cont_sample k=%0d: got %h want %h", k, bus.speed_sample, 16'(k - 1)); end
                checks++; if (bus.win_count !== 16'((k - 12) / 10 + 1)) begin errors++; $display("FAIL cont_win k=%0d: got %0d want %0d", k, bus.win_count, (k - 12) / 10 + 1); end
            end
            step();
        end
        checks++; if (bus.position !== 32'd63) begin errors++; $display("FAIL cont_pos: got %0d want 63", bus.position); end
        bus.enable = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", bus.busy); end
        checks++; if (bus.win_count !== 16'd3) begin errors++; $display("FAIL cont_stop_win: got %0d want 3", bus.win_count); end
    endtask

    task automatic test_single_shot();
        int nvld;
        do_reset();
        bus.single = 1'b1; bus.enable = 1'b1; bus.cfg_period = 24'd5; bus.cnt_in = 16'hFFFD;
        step(); step(); step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_nostart_busy: got %b want 0", bus.busy); end
        bus.start = 1'b1;
        step();
        nvld = 0;
        for (int k = 1; k < 26; k++) begin
            bus.start = (k == 3);
            if (bus.speed_valid === 1'b1) nvld++;
            if (k == 1) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_arm_busy: got %b want 1", bus.busy); end
            end
            if (k == 6) begin
                checks++; if (bus.busy !== 1'b1 || bus.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL single_capture: busy %b clr %b want 1 0", bus.busy, bus.cnt_clr_n); end
            end
            if (k == 7) begin
                checks++; if (bus.speed_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.speed_valid); end
                checks++; if (bus.speed_sample !== 16'hFFFD) begin errors++; $display("FAIL single_sample: got %h want fffd", bus.speed_sample); end
                checks++; if (bus.position !== 32'hFFFF_FFFD) begin errors++; $display("FAIL single_pos: got %h want fffffffd", bus.position); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
                checks++; if (bus.win_count !== 16'd1) begin errors++; $display("FAIL single_win: got %0d want 1", bus.win_count); end
            end
            step();
        end
        checks++; if (nvld != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", nvld); end
        bus.enable = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_disabled_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.cfg_period = 24'd4; bus.single = 1'b0; bus.enable = 1'b1;
        for (int k = 0; k < 15; k++) begin
            case (k)
                5:       bus.cnt_in = 16'h7FFF;
                9:       bus.cnt_in = 16'h8001;
                13:      bus.cnt_in = 16'h0004;
                default: bus.cnt_in = 16'h1111;
            endcase
            if (k == 6) begin
                checks++; if (bus.speed_sat !== 1'b1) begin errors++; $display("FAIL sat_pos: got %b want 1", bus.speed_sat); end
                checks++; if (bus.position !== 32'h0000_7FFF) begin errors++; $display("FAIL sat_pos_acc: got %h want 00007fff", bus.position); end
            end
            if (k == 10) begin
                checks++; if (bus.speed_sat !== 1'b1) begin errors++; $display("FAIL sat_neg: got %b want 1", bus.speed_sat); end
                checks++; if (bus.speed_sample !== 16'h8001) begin errors++; $display("FAIL sat_neg_sample: got %h want 8001", bus.speed_sample); end
                checks++; if (bus.position !== 32'h0) begin errors++; $display("FAIL sat_neg_acc: got %h want 0", bus.position); end
            end
            if (k == 14) begin
                checks++; if (bus.speed_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b want 0", bus.speed_sat); end
                checks++; if (bus.position !== 32'h4) begin errors++; $display("FAIL sat_clear_acc: got %h want 4", bus.position); end
            end
            step();
        end
        bus.enable = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int nvld;
        do_reset();
        bus.cfg_period = 24'd20; bus.single = 1'b0; bus.cnt_in = 16'd5;
        nvld = 0;
        for (int k = 0; k < 60; k++) begin
            bus.enable = (k < 24);
            if (k > 22 && bus.speed_valid === 1'b1) nvld++;
            if (k == 22) begin
                checks++; if (bus.speed_valid !== 1'b1 || bus.position !== 32'd5) begin errors++; $display("FAIL abort_first: valid %b pos %0d want 1 5", bus.speed_valid, bus.position); end
            end
            if (k == 25) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
                checks++; if (bus.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL abort_clr: got %b want 0", bus.cnt_clr_n); end
            end
            step();
        end
        checks++; if (nvld != 0) begin errors++; $display("FAIL abort_valid_count: got %0d want 0", nvld); end
        checks++; if (bus.position !== 32'd5) begin errors++; $display("FAIL abort_pos: got %0d want 5", bus.position); end
        checks++; if (bus.win_count !== 16'd1) begin errors++; $display("FAIL abort_win: got %0d want 1", bus.win_count); end
    endtask

    task automatic test_pos_clr();
        do_reset();
        bus.single = 1'b1; bus.enable = 1'b1; bus.cfg_period = 24'd5;
        for (int k = 0; k < 17; k++) begin
            bus.start   = (k == 0) || (k == 7);
            bus.cnt_in  = (k < 8) ? 16'd100 : 16'd7;
            bus.pos_clr = (k == 13) || (k == 15);
            if (k == 7) begin
                checks++; if (bus.position !== 32'd100) begin errors++; $display("FAIL posclr_pre: got %0d want 100", bus.position); end
            end
            if (k == 14) begin
                checks++; if (bus.position !== 32'd7) begin errors++; $display("FAIL posclr_coincident: got %0d want 7", bus.position); end
                checks++; if (bus.win_count !== 16'd2) begin errors++; $display("FAIL posclr_win: got %0d want 2", bus.win_count); end
            end
            if (k == 16) begin
                checks++; if (bus.position !== 32'd0) begin errors++; $display("FAIL posclr_alone: got %0d want 0", bus.position); end
            end
            step();
        end
        bus.start = 1'b0; bus.pos_clr = 1'b0;
    endtask

    task automatic test_min_period();
        logic exp_clr, exp_vld;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            bus.cfg_period = 24'(p); bus.single = 1'b0; bus.enable = 1'b1; bus.cnt_in = 16'd3;
            for (int k = 0; k < 9; k++) begin
                exp_clr = (k >= 2) && (k % 2 == 0);
                exp_vld = (k >= 4) && (k % 2 == 0);
                checks++; if (bus.cnt_clr_n !== exp_clr) begin errors++; $display("FAIL minper_clr p=%0d k=%0d: got %b want %b", p, k, bus.cnt_clr_n, exp_clr); end
                checks++; if (bus.speed_valid !== exp_vld) begin errors++; $display("FAIL minper_valid p=%0d k=%0d: got %b want %b", p, k, bus.speed_valid, exp_vld); end
                step();
            end
            checks++; if (bus.win_count !== 16'd3) begin errors++; $display("FAIL minper_win p=%0d: got %0d want 3", p, bus.win_count); end
            bus.enable = 1'b0;
            step();
        end
    endtask

    task automatic test_async_reset();
        logic exp_clr;
        do_reset();
        bus.single = 1'b1; bus.enable = 1'b1; bus.cfg_period = 24'd5; bus.cnt_in = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            bus.start = (k == 0);
            if (k == 7) begin
                checks++; if (bus.position !== 32'h1234) begin errors++; $display("FAIL arst_pre_pos: got %h want 1234", bus.position); end
                bus.single = 1'b0;
            end
            step();
        end
        checks++; if (bus.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL arst_in_count: got %b want 1", bus.cnt_clr_n); end
        rst = 1'b1;
        #1;
        checks++; if (bus.position !== 32'h0) begin errors++; $display("FAIL arst_pos: got %h want 0", bus.position); end
        checks++; if (bus.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL arst_clr: got %b want 0", bus.cnt_clr_n); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.win_count !== 16'h0 || bus.speed_sample !== 16'h0) begin errors++; $display("FAIL arst_regs: win %h sample %h want 0 0", bus.win_count, bus.speed_sample); end
        bus.cfg_period = 24'd7;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_clr = ((k >= 2) && (k <= 7)) || (k == 9);
            checks++; if (bus.cnt_clr_n !== exp_clr) begin errors++; $display("FAIL arst_restart_clr k=%0d: got %b want %b", k, bus.cnt_clr_n, exp_clr); end
            step();
        end
        bus.enable = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_continuous();
        test_single_shot();
        test_saturation();
        test_abort();
        test_pos_clr();
        test_min_period();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/encoder_sample_ctrl.md
Name: encoder_sample_ctrl

Overview:
Sequences the quadrature 4x-pulse counter into fixed-length, back-to-back measurement windows. Drives the counter's active-low clear, captures the signed window count as a speed sample, and flags saturation. Keeps a 32-bit signed position accumulator. Sits between the encoder counter and the register/AXI slave layer of the Quadrature Encoder IP.

Parameters:
CNT_W, 16, width of the encoder counter value (two's complement)
WIN_W, 24, width of the window period in clk cycles
POS_W, 32, width of the position accumulator

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  level; 1 = run windows, 0 = stop/abort
single  in  1  1 = one window per start pulse, 0 = continuous
start  in  1  one-cycle pulse; arms a single-shot window (ignored when single=0)
cfg_period  in  WIN_W  window length in clk cycles; latched at each window start
pos_clr  in  1  one-cycle pulse; clears position accumulator
cnt_in  in  CNT_W  current encoder counter value (signed)
cnt_clr_n  out  1  to counter: 0 = clear/restart window, 1 = count
speed_sample  out  CNT_W  last captured window count (signed)
speed_valid  out  1  one-cycle pulse when speed_sample updates
speed_sat  out  1  captured sample hit +32767 or -32767 (sticky per sample)
position  out  POS_W  signed running sum of all samples
win_count  out  16  number of completed windows, wraps at 0xFFFF->0
busy  out  1  1 when not IDLE

Behaviour:
- Reset: cnt_clr_n=0, speed_sample=0, speed_valid=0, speed_sat=0, position=0, win_count=0, busy=0, state=IDLE, timer=0.
- Effective period P = max(cfg_period, 2). It is latched into the timer when entering COUNT, so mid-window cfg_period changes take effect at the next window.
- States: IDLE, ARM, COUNT, CAPTURE.
- IDLE: cnt_clr_n=0 (counter held clear).
  - Leave to ARM if enable=1 and single=0.
  - Leave to ARM if enable=1, single=1 and start=1.
- ARM: cnt_clr_n=0 for exactly 1 cycle; load timer=P-2; go to COUNT.
- COUNT: cnt_clr_n=1; timer decrements each cycle; at timer==0 go to CAPTURE.
- CAPTURE: cnt_clr_n=0 for 1 cycle. On this edge:
  - speed_sample<=cnt_in
  - speed_sat<=(cnt_in==0x7FFF || cnt_in==0x8001)
  - position<=position+sign_extend(cnt_in)
  - win_count<=win_count+1
  - speed_valid=1 on the following cycle (registered pulse)
  - Next state: if enable=1 and single=0, reload timer=P-2 and go to COUNT (no ARM; the clear cycle doubles as the restart). Otherwise go to IDLE.
- Window length: exactly P cycles from clear cycle to clear cycle. An edge arriving in the clear cycle is counted into the new window (counter loads ±1), so no edge is lost.
- Abort: enable=0 in ARM or COUNT goes to IDLE next cycle. No sample, no speed_valid, position and win_count unchanged.
- enable=0 in CAPTURE: the capture completes normally, then the block goes to IDLE.
- start while busy: ignored. start with enable=0: ignored.
- pos_clr: position<=0. If pos_clr and a capture land on the same cycle, position<=sign_extend(cnt_in) (clear, then add).
- position wraps modulo 2^POS_W; no saturation.
- single toggled mid-window: sampled only in CAPTURE to decide between continue and IDLE.
- busy=0 only in IDLE.
- Async rst mid-window: immediate return to reset values; cnt_clr_n=0.

Decomposition:
- Shared package enc_pkg holds:
  - state encoding localparams (ST_IDLE=2'b00, ST_ARM=2'b01, ST_COUNT=2'b11, ST_CAPTURE=2'b10)
  - CNT_SAT_POS=16'h7FFF, CNT_SAT_NEG=16'h8001
  - MIN_PERIOD=2
- One natural sub-module, enc_window_timer: loadable down-counter with a zero flag (load, dec, value, zero). The FSM, capture and accumulator stay in the top.

Test Plan:
1. Continuous, cfg_period=10, cnt_in ramps +1 per cycle from 0 -> cnt_clr_n low every 10th cycle; speed_valid every 10 cycles; speed_sample equals cnt_in at each clear edge; win_count increments 1,2,3...
2. single=1, cfg_period=5, start pulse, cnt_in=-3 at capture -> exactly one speed_valid; speed_sample=0xFFFD; position=-3; busy drops after CAPTURE; no further windows without another start.
3. cnt_in=0x7FFF at capture, next window cnt_in=0x8001, then 0x0004 -> speed_sat=1, 1, 0 respectively; position=0x7FFF, 0x0000, 0x0004.
4. enable deasserted at cycle 4 of a 20-cycle window -> IDLE next cycle; cnt_clr_n=0; no speed_valid; position and win_count unchanged.
5. pos_clr coincident with capture of cnt_in=7 when position=100 -> position=7. cfg_period=0 or 1 -> window measured as 2 cycles.
6. rst asserted mid-COUNT with position=0x1234 -> all outputs reset immediately; cnt_clr_n=0; restart on enable gives a first window of exactly P cycles.
